// File: rtl/dmem_arb_pkg.sv
// dmem_arbiter shared types: owner encoding, read-return tag, burst width.
// Helpers map an owner to its one-hot grant and to the opposite master.
package dmem_arb_pkg;

  localparam int BURST_W = 4;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t master;
  } rd_tag_t;

  function automatic owner_t other_of(input owner_t o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

  function automatic logic [1:0] onehot(input owner_t o);
    return (o == OWN_M1) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle of dmem_arbiter: core port (M0), loader port (M1), RAM port.
// slave = arbiter side, master = the requesters plus the RAM around it.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic              M0_READ;
  logic              M0_WRITE;
  logic [ADDR_W-1:0] M0_ADDR;
  logic [DATA_W-1:0] M0_WDATA;
  logic              M0_STALL;
  logic [DATA_W-1:0] M0_RDATA;
  logic              M0_RVALID;

  logic              M1_REQ;
  logic              M1_WE;
  logic [ADDR_W-1:0] M1_ADDR;
  logic [DATA_W-1:0] M1_WDATA;
  logic              M1_GNT;
  logic [DATA_W-1:0] M1_RDATA;
  logic              M1_RVALID;

  logic              RAM_CS;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;

  logic [CNT_W-1:0]  CONTENTION;

  modport slave (
    input  M0_READ, M0_WRITE, M0_ADDR, M0_WDATA,
    output M0_STALL, M0_RDATA, M0_RVALID,
    input  M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
    output M1_GNT, M1_RDATA, M1_RVALID,
    output RAM_CS, RAM_WE, RAM_ADDR, RAM_WDATA,
    input  RAM_RDATA,
    output CONTENTION
  );

  modport master (
    output M0_READ, M0_WRITE, M0_ADDR, M0_WDATA,
    input  M0_STALL, M0_RDATA, M0_RVALID,
    output M1_REQ, M1_WE, M1_ADDR, M1_WDATA,
    input  M1_GNT, M1_RDATA, M1_RVALID,
    input  RAM_CS, RAM_WE, RAM_ADDR, RAM_WDATA,
    output RAM_RDATA,
    input  CONTENTION
  );

endinterface

// File: rtl/dmem_arb_rr_core.sv
// Burst-limited two-way grant core: CLK, RESET_N, req[1:0] in, gnt[1:0] out.
// Holds the last owner and its consecutive-grant count; grant is combinational.
module dmem_arb_rr_core
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [BURST_W-1:0] B_MAX = BURST_W'(MAX_BURST);
  localparam logic [BURST_W-1:0] B_ONE = BURST_W'(1);

  owner_t             owner;
  logic [BURST_W-1:0] burst;
  logic               keep;
  logic               to_owner;

  // burst==0 only right after reset: the owner never actually
  // got a grant, so contention goes to the other master (M0).
  assign keep = (burst != '0) && (burst < B_MAX);

  always_comb begin
    gnt = 2'b00;
    if (RESET_N) begin
      unique case (1'b1)
        (req == 2'b11):
          gnt = keep ? onehot(owner)
                     : onehot(other_of(owner));
        default:
          gnt = req;
      endcase
    end
  end

  assign to_owner = (gnt == onehot(owner));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      owner <= OWN_M1;
      burst <= '0;
    end else if (gnt != 2'b00) begin
      if (to_owner) begin
        if (burst < B_MAX) burst <= burst + B_ONE;
      end else begin
        owner <= other_of(owner);
        burst <= B_ONE;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core (M0) and loader (M1).
// Ports: CLK, RESET_N (sync, active-low), bus (dmem_arbiter_if.slave).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input logic           CLK,
  input logic           RESET_N,
  dmem_arbiter_if.slave bus
);

  logic              m0_req;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              rd_gnt;
  rd_tag_t           tag;
  logic              m0_hit;
  logic              m1_hit;
  logic [CNT_W-1:0]  cnt;

  assign m0_req = bus.M0_READ | bus.M0_WRITE;
  assign req    = {bus.M1_REQ, m0_req};

  dmem_arb_rr_core #(
    .MAX_BURST(MAX_BURST)
  ) u_core (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .req    (req),
    .gnt    (gnt)
  );

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        ram_we    = bus.M0_WRITE;
        ram_addr  = bus.M0_ADDR;
        ram_wdata = bus.M0_WDATA;
      end
      gnt[1]: begin
        ram_we    = bus.M1_WE;
        ram_addr  = bus.M1_ADDR;
        ram_wdata = bus.M1_WDATA;
      end
      default: ;
    endcase
  end

  assign bus.RAM_CS    = |gnt;
  assign bus.RAM_WE    = ram_we;
  assign bus.RAM_ADDR  = ram_addr;
  assign bus.RAM_WDATA = ram_wdata;

  // Combinational so the core freezes PC/regfile write this cycle.
  assign bus.M0_STALL = RESET_N & m0_req & ~gnt[0];
  assign bus.M1_GNT   = gnt[1];

  assign rd_gnt = (gnt[0] & bus.M0_READ)
                | (gnt[1] & ~bus.M1_WE);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      tag <= '{valid: 1'b0, master: OWN_M0};
    end else begin
      tag.valid  <= rd_gnt;
      tag.master <= gnt[1] ? OWN_M1 : OWN_M0;
    end
  end

  // Gated by RESET_N so a read in flight is dropped at once.
  assign m0_hit = RESET_N & tag.valid
                & (tag.master == OWN_M0);
  assign m1_hit = RESET_N & tag.valid
                & (tag.master == OWN_M1);

  assign bus.M0_RVALID = m0_hit;
  assign bus.M1_RVALID = m1_hit;
  assign bus.M0_RDATA  = m0_hit ? bus.RAM_RDATA : '0;
  assign bus.M1_RDATA  = m1_hit ? bus.RAM_RDATA : '0;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (m0_req & bus.M1_REQ & (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bus.CONTENTION = cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a RAM model and a reference model.
// A second instance (MAX_BURST=1, CNT_W=4) covers alternation and saturation.
module tb_dmem_arbiter;

  localparam int MAXB = 4;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) bus ();
  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(4))  bus2 ();

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(MAXB), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus)
  );

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_BURST(1), .CNT_W(4)
  ) dut2 (
    .CLK(CLK), .RESET_N(RESET_N), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;

  // Unwritten words read back as an address-dependent pattern.
  function automatic logic [31:0] fill(input logic [31:0] a);
    return 32'hDEADBEEF ^ ((a ^ 32'h10) << 8);
  endfunction

  // RAM environment: 64 words, registered read.
  logic [31:0] ram [64];
  bit          ramv [64];
  always @(posedge CLK) begin
    if (bus.RAM_CS) begin
      if (bus.RAM_WE) begin
        ram[bus.RAM_ADDR[7:2]]  <= bus.RAM_WDATA;
        ramv[bus.RAM_ADDR[7:2]] <= 1'b1;
      end else begin
        bus.RAM_RDATA <= ramv[bus.RAM_ADDR[7:2]] ?
          ram[bus.RAM_ADDR[7:2]] : fill(bus.RAM_ADDR);
      end
    end
  end

  // Reference model: who owned the bus last, how many grants in a row.
  int          last = 1;
  int          run = 0;
  int          g = -1;
  int unsigned cont = 0;
  bit          e_cs, e_we, e_stall, e_m1g, e_rv0, e_rv1;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [31:0] mm [64];
  bit          mv [64];

  function automatic logic [31:0] mread(input logic [31:0] a);
    return mv[a[7:2]] ? mm[a[7:2]] : fill(a);
  endfunction

  task automatic predict();
    bit r0, r1;
    r0 = bus.M0_READ | bus.M0_WRITE;
    r1 = bus.M1_REQ;
    g = -1;
    if (RESET_N !== 1'b1) g = -1;
    else if (r0 && r1) g = (run > 0 && run < MAXB) ? last : 1 - last;
    else if (r0) g = 0;
    else if (r1) g = 1;
    e_cs = (g >= 0);
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (g == 0) begin
      e_we = bus.M0_WRITE; e_addr = bus.M0_ADDR; e_wdata = bus.M0_WDATA;
    end
    if (g == 1) begin
      e_we = bus.M1_WE; e_addr = bus.M1_ADDR; e_wdata = bus.M1_WDATA;
    end
    e_stall = (RESET_N === 1'b1) && r0 && (g != 0);
    e_m1g = (g == 1);
  endtask

  task automatic advance();
    bit both, rd;
    logic [31:0] a;
    both = (bus.M0_READ | bus.M0_WRITE) && bus.M1_REQ;
    rd = (g == 0 && bus.M0_READ) || (g == 1 && !bus.M1_WE);
    a = e_addr;
    @(posedge CLK);
    if (RESET_N !== 1'b1) begin
      last = 1; run = 0; cont = 0;
      e_rv0 = 0; e_rv1 = 0; e_rd = '0;
    end else begin
      if (g == last) run = (run < MAXB) ? run + 1 : run;
      else if (g >= 0) begin last = g; run = 1; end
      if (both && cont < 65535) cont++;
      if (e_cs && e_we) begin mm[a[7:2]] = e_wdata; mv[a[7:2]] = 1'b1; end
      e_rv0 = rd && (g == 0);
      e_rv1 = rd && (g == 1);
      e_rd = rd ? mread(a) : '0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    bus.M0_READ = 0; bus.M0_WRITE = 0; bus.M0_ADDR = '0; bus.M0_WDATA = '0;
    bus.M1_REQ = 0; bus.M1_WE = 0; bus.M1_ADDR = '0; bus.M1_WDATA = '0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    clear_inputs();
    predict();
    advance();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    bus.M0_READ = 1; bus.M1_REQ = 1; bus.M1_WE = 1;
    predict();
    #1;
    checks++; if (bus.M0_STALL !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", bus.M0_STALL); end
    checks++; if (bus.M1_GNT !== 1'b0) begin errors++; $display("FAIL rst_m1gnt got %b exp 0", bus.M1_GNT); end
    checks++; if (bus.RAM_CS !== 1'b0) begin errors++; $display("FAIL rst_cs got %b exp 0", bus.RAM_CS); end
    checks++; if (bus.RAM_WE !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus.RAM_WE); end
    advance();
    RESET_N = 1'b1;
    clear_inputs();
    #1;
    checks++; if (bus.M0_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rv0 got %b exp 0", bus.M0_RVALID); end
    checks++; if (bus.M1_RVALID !== 1'b0) begin errors++; $display("FAIL rst_rv1 got %b exp 0", bus.M1_RVALID); end
    checks++; if (bus.M0_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rd0 got %h exp 0", bus.M0_RDATA); end
    checks++; if (bus.M1_RDATA !== 32'h0) begin errors++; $display("FAIL rst_rd1 got %h exp 0", bus.M1_RDATA); end
    checks++; if (bus.CONTENTION !== 16'h0) begin errors++; $display("FAIL rst_cont got %h exp 0", bus.CONTENTION); end
  endtask

  task automatic test_m0_read();
    clear_inputs();
    bus.M0_READ = 1; bus.M0_ADDR = 32'h10;
    predict();
    #1;
    checks++; if (bus.RAM_CS !== 1'b1) begin errors++; $display("FAIL m0rd_cs got %b exp 1", bus.RAM_CS); end
    checks++; if (bus.RAM_WE !== 1'b0) begin errors++; $display("FAIL m0rd_we got %b exp 0", bus.RAM_WE); end
    checks++; if (bus.RAM_ADDR !== 32'h10) begin errors++; $display("FAIL m0rd_addr got %h exp 10", bus.RAM_ADDR); end
    checks++; if (bus.M0_STALL !== 1'b0) begin errors++; $display("FAIL m0rd_stall got %b exp 0", bus.M0_STALL); end
    advance();
    clear_inputs();
    #1;
    checks++; if (bus.M0_RVALID !== 1'b1) begin errors++; $display("FAIL m0rd_rv got %b exp 1", bus.M0_RVALID); end
    checks++; if (bus.M0_RDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL m0rd_data got %h exp deadbeef", bus.M0_RDATA); end
    checks++; if (bus.M1_RVALID !== 1'b0) begin errors++; $display("FAIL m0rd_rv1 got %b exp 0", bus.M1_RVALID); end
  endtask

  task automatic test_m1_write();
    clear_inputs();
    bus.M1_REQ = 1; bus.M1_WE = 1; bus.M1_ADDR = 32'h4; bus.M1_WDATA = 32'h13;
    predict();
    #1;
    checks++; if (bus.M1_GNT !== 1'b1) begin errors++; $display("FAIL m1wr_gnt got %b exp 1", bus.M1_GNT); end
    checks++; if (bus.RAM_WE !== 1'b1) begin errors++; $display("FAIL m1wr_we got %b exp 1", bus.RAM_WE); end
    checks++; if (bus.RAM_WDATA !== 32'h13) begin errors++; $display("FAIL m1wr_wdata got %h exp 13", bus.RAM_WDATA); end
    checks++; if (bus.RAM_ADDR !== 32'h4) begin errors++; $display("FAIL m1wr_addr got %h exp 4", bus.RAM_ADDR); end
    advance();
    checks++; if (bus.M0_RVALID !== 1'b0) begin errors++; $display("FAIL m1wr_rv0 got %b exp 0", bus.M0_RVALID); end
    checks++; if (bus.M1_RVALID !== 1'b0) begin errors++; $display("FAIL m1wr_rv1 got %b exp 0", bus.M1_RVALID); end
    bus.M1_WE = 0; bus.M1_WDATA = '0;
    predict();
    #1;
    checks++; if (bus.M1_GNT !== 1'b1) begin errors++; $display("FAIL b2b_gnt got %b exp 1", bus.M1_GNT); end
    advance();
    clear_inputs();
    #1;
    checks++; if (bus.M1_RVALID !== 1'b1) begin errors++; $display("FAIL b2b_rv1 got %b exp 1", bus.M1_RVALID); end
    checks++; if (bus.M1_RDATA !== 32'h13) begin errors++; $display("FAIL b2b_rd1 got %h exp 13", bus.M1_RDATA); end
    checks++; if (bus.M0_RVALID !== 1'b0) begin errors++; $display("FAIL b2b_rv0 got %b exp 0", bus.M0_RVALID); end
  endtask

  task automatic test_burst();
    int exp_g [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    do_reset();
    bus.M0_READ = 1; bus.M0_ADDR = 32'h20;
    bus.M1_REQ = 1; bus.M1_WE = 1; bus.M1_ADDR = 32'h40;
    for (int i = 0; i < 9; i++) begin
      bus.M1_WDATA = $urandom();
      predict();
      #1;
      checks++; if (bus.M1_GNT !== (exp_g[i] == 1)) begin errors++; $display("FAIL burst_gnt[%0d] got %b exp %0d", i, bus.M1_GNT, exp_g[i]); end
      checks++; if (bus.M0_STALL !== (exp_g[i] == 1)) begin errors++; $display("FAIL burst_stall[%0d] got %b exp %0d", i, bus.M0_STALL, exp_g[i]); end
      checks++; if (bus.RAM_ADDR !== e_addr) begin errors++; $display("FAIL burst_addr[%0d] got %h exp %h", i, bus.RAM_ADDR, e_addr); end
      advance();
      checks++; if (bus.M0_RVALID !== e_rv0) begin errors++; $display("FAIL burst_rv0[%0d] got %b exp %b", i, bus.M0_RVALID, e_rv0); end
      checks++; if (bus.M0_RDATA !== e_rd) begin errors++; $display("FAIL burst_rd0[%0d] got %h exp %h", i, bus.M0_RDATA, e_rd); end
      if (i == 7) begin
        checks++; if (bus.CONTENTION !== 16'd8) begin errors++; $display("FAIL burst_cont got %0d exp 8", bus.CONTENTION); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_m1_then_both();
    int exp_a [3] = '{1, 1, 0};
    do_reset();
    bus.M1_REQ = 1; bus.M1_WE = 1;
    for (int i = 0; i < 18; i++) begin
      bus.M1_ADDR = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      bus.M1_WDATA = $urandom();
      predict();
      #1;
      checks++; if (bus.M1_GNT !== 1'b1) begin errors++; $display("FAIL solo_gnt[%0d] got %b exp 1", i, bus.M1_GNT); end
      advance();
    end
    bus.M0_WRITE = 1; bus.M0_ADDR = 32'h8; bus.M0_WDATA = $urandom();
    predict();
    #1;
    checks++; if (bus.M1_GNT !== 1'b0) begin errors++; $display("FAIL sat_m1gnt got %b exp 0", bus.M1_GNT); end
    checks++; if (bus.M0_STALL !== 1'b0) begin errors++; $display("FAIL sat_stall got %b exp 0", bus.M0_STALL); end
    advance();
    do_reset();
    bus.M1_REQ = 1; bus.M1_WE = 1; bus.M1_ADDR = 32'h30;
    for (int i = 0; i < 2; i++) begin predict(); advance(); end
    bus.M0_WRITE = 1; bus.M0_ADDR = 32'hC;
    for (int i = 0; i < 3; i++) begin
      predict();
      #1;
      checks++; if (bus.M1_GNT !== (exp_a[i] == 1)) begin errors++; $display("FAIL short_gnt[%0d] got %b exp %0d", i, bus.M1_GNT, exp_a[i]); end
      advance();
    end
    clear_inputs();
  endtask

  task automatic test_reset_inflight();
    clear_inputs();
    bus.M1_REQ = 1; bus.M1_ADDR = 32'h8;
    predict();
    advance();
    RESET_N = 1'b0;
    bus.M0_READ = 1;
    predict();
    #1;
    checks++; if (bus.M1_RVALID !== 1'b0) begin errors++; $display("FAIL infl_rv1a got %b exp 0", bus.M1_RVALID); end
    checks++; if (bus.M1_RDATA !== 32'h0) begin errors++; $display("FAIL infl_rd1 got %h exp 0", bus.M1_RDATA); end
    checks++; if (bus.M1_GNT !== 1'b0) begin errors++; $display("FAIL infl_gnt got %b exp 0", bus.M1_GNT); end
    checks++; if (bus.RAM_CS !== 1'b0) begin errors++; $display("FAIL infl_cs got %b exp 0", bus.RAM_CS); end
    checks++; if (bus.M0_STALL !== 1'b0) begin errors++; $display("FAIL infl_stall got %b exp 0", bus.M0_STALL); end
    advance();
    RESET_N = 1'b1;
    clear_inputs();
    #1;
    checks++; if (bus.M1_RVALID !== 1'b0) begin errors++; $display("FAIL infl_rv1b got %b exp 0", bus.M1_RVALID); end
    checks++; if (bus.M0_RVALID !== 1'b0) begin errors++; $display("FAIL infl_rv0 got %b exp 0", bus.M0_RVALID); end
    bus.M0_READ = 1; bus.M0_ADDR = 32'hC;
    bus.M1_REQ = 1; bus.M1_ADDR = 32'h18;
    predict();
    #1;
    checks++; if (bus.M1_GNT !== 1'b0) begin errors++; $display("FAIL infl_first_gnt got %b exp 0", bus.M1_GNT); end
    checks++; if (bus.RAM_ADDR !== 32'hC) begin errors++; $display("FAIL infl_first_addr got %h exp c", bus.RAM_ADDR); end
    advance();
    clear_inputs();
    #1;
    checks++; if (bus.M0_RVALID !== 1'b1) begin errors++; $display("FAIL infl_first_rv got %b exp 1", bus.M0_RVALID); end
  endtask

  task automatic test_alternate_sat();
    int c;
    do_reset();
    bus2.M0_WRITE = 1; bus2.M1_REQ = 1; bus2.M1_WE = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      checks++; if (bus2.M1_GNT !== 1'(i % 2)) begin errors++; $display("FAIL alt_gnt[%0d] got %b exp %0d", i, bus2.M1_GNT, i % 2); end
      checks++; if (bus2.M0_STALL !== 1'(i % 2)) begin errors++; $display("FAIL alt_stall[%0d] got %b exp %0d", i, bus2.M0_STALL, i % 2); end
      @(posedge CLK);
      #1;
      c = (i + 1 > 15) ? 15 : i + 1;
      checks++; if (bus2.CONTENTION !== 4'(c)) begin errors++; $display("FAIL alt_cont[%0d] got %0d exp %0d", i, bus2.CONTENTION, c); end
    end
    bus2.M0_WRITE = 0; bus2.M1_REQ = 0; bus2.M1_WE = 0;
  endtask

  task automatic test_random();
    bit p0, p1;
    int n;
    do_reset();
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      RESET_N = ($urandom_range(0, 39) != 0);
      if (!p0) begin
        n = $urandom_range(0, 3);
        bus.M0_READ = (n == 1); bus.M0_WRITE = (n == 2);
        bus.M0_ADDR = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.M0_WDATA = $urandom();
        p0 = (n == 1) || (n == 2);
      end
      if (!p1) begin
        n = $urandom_range(0, 2);
        bus.M1_REQ = (n != 0); bus.M1_WE = (n == 2);
        bus.M1_ADDR = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        bus.M1_WDATA = $urandom();
        p1 = (n != 0);
      end
      predict();
      #1;
      checks++; if (bus.M0_STALL !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b exp %b", i, bus.M0_STALL, e_stall); end
      checks++; if (bus.M1_GNT !== e_m1g) begin errors++; $display("FAIL rnd_m1gnt[%0d] got %b exp %b", i, bus.M1_GNT, e_m1g); end
      checks++; if (bus.RAM_CS !== e_cs) begin errors++; $display("FAIL rnd_cs[%0d] got %b exp %b", i, bus.RAM_CS, e_cs); end
      checks++; if (bus.RAM_WE !== e_we) begin errors++; $display("FAIL rnd_we[%0d] got %b exp %b", i, bus.RAM_WE, e_we); end
      checks++; if (bus.RAM_ADDR !== e_addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, bus.RAM_ADDR, e_addr); end
      checks++; if (bus.RAM_WDATA !== e_wdata) begin errors++; $display("FAIL rnd_wdata[%0d] got %h exp %h", i, bus.RAM_WDATA, e_wdata); end
      advance();
      checks++; if (bus.M0_RVALID !== e_rv0) begin errors++; $display("FAIL rnd_rv0[%0d] got %b exp %b", i, bus.M0_RVALID, e_rv0); end
      checks++; if (bus.M1_RVALID !== e_rv1) begin errors++; $display("FAIL rnd_rv1[%0d] got %b exp %b", i, bus.M1_RVALID, e_rv1); end
      checks++; if (bus.M0_RDATA !== (e_rv0 ? e_rd : 32'h0)) begin errors++; $display("FAIL rnd_rd0[%0d] got %h exp %h", i, bus.M0_RDATA, e_rv0 ? e_rd : 32'h0); end
      checks++; if (bus.M1_RDATA !== (e_rv1 ? e_rd : 32'h0)) begin errors++; $display("FAIL rnd_rd1[%0d] got %h exp %h", i, bus.M1_RDATA, e_rv1 ? e_rd : 32'h0); end
      checks++; if (bus.CONTENTION !== 16'(cont)) begin errors++; $display("FAIL rnd_cont[%0d] got %0d exp %0d", i, bus.CONTENTION, cont); end
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end
    RESET_N = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    bus2.M0_READ = 0; bus2.M0_WRITE = 0; bus2.M0_ADDR = '0; bus2.M0_WDATA = '0;
    bus2.M1_REQ = 0; bus2.M1_WE = 0; bus2.M1_ADDR = '0; bus2.M1_WDATA = '0;
    bus2.RAM_RDATA = '0;
    clear_inputs();
    do_reset();
    test_reset();
    test_m0_read();
    test_m1_write();
    test_burst();
    test_m1_then_both();
    test_reset_inflight();
    test_alternate_sat();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
